// File: rtl/output_collect_fifo.sv
`default_nettype none
// ============================================================================
// Module      : output_collect_fifo
// Description : Multi-port collection FIFO for unquantized matrix outputs.
//               Up to NUM_WRITE_PORTS entries are packed per cycle in port
//               order; a single consumer pops the head. An optional
//               empty-buffer bypass presents the lowest valid port directly.
// Revision    : 1.0 - initial release
// ============================================================================
module output_collect_fifo #(
  parameter int MAX_N           = 512,
  parameter int N_BITS          = $clog2(MAX_N),
  parameter int NUM_WRITE_PORTS = 4,
  parameter int DEPTH           = 8,
  parameter int BYPASS_EN       = 1,
  parameter int AFULL_THRESH    = DEPTH - NUM_WRITE_PORTS,
  parameter int CNT_BITS        = $clog2(DEPTH + 1),
  parameter int PTR_BITS        = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_WRITE_PORTS-1:0]             in_valid,
  input  logic [NUM_WRITE_PORTS-1:0][31:0]       in_output,
  input  logic [NUM_WRITE_PORTS-1:0][N_BITS-1:0] in_row,
  input  logic [NUM_WRITE_PORTS-1:0][N_BITS-1:0] in_col,
  output logic                                   in_ready,
  input  logic                                   flush,
  output logic                                   out_valid,
  output logic [31:0]                            out_output,
  output logic [N_BITS-1:0]                      out_row,
  output logic [N_BITS-1:0]                      out_col,
  input  logic                                   out_consume,
  output logic [CNT_BITS-1:0]                    count,
  output logic                                   almost_full,
  output logic                                   overflow_err,
  output logic                                   idle
);

  localparam int ENTRY_W = 32 + 2 * N_BITS;
  localparam logic [CNT_BITS-1:0] C_DEPTH  = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] C_NWP    = CNT_BITS'(NUM_WRITE_PORTS);
  localparam logic [CNT_BITS-1:0] C_AFULL  = CNT_BITS'(AFULL_THRESH);

  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [CNT_BITS-1:0] r_count;
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic                r_overflow;

  logic                                   w_in_ready;
  logic                                   w_any_valid;
  logic                                   w_bypass;
  logic                                   w_byp_consumed;
  logic [ENTRY_W-1:0]                     w_byp_data;
  logic [NUM_WRITE_PORTS-1:0]             w_low_onehot;
  logic [NUM_WRITE_PORTS-1:0]             w_store;
  logic [NUM_WRITE_PORTS-1:0][PTR_BITS-1:0] w_slot;
  logic [CNT_BITS-1:0]                    w_nstore;
  logic                                   w_out_valid;
  logic                                   w_pop;
  logic                                   w_overflow;
  logic [CNT_BITS-1:0]                    w_free;

  // Accept decision depends only on registered occupancy, flush and reset.
  assign w_free      = C_DEPTH - r_count;
  assign w_in_ready  = reset && !flush && (w_free >= C_NWP);
  assign w_any_valid = |in_valid;
  // Isolate the lowest-index asserted port (two's-complement trick).
  assign w_low_onehot = in_valid & (~in_valid + NUM_WRITE_PORTS'(1));

  if (BYPASS_EN != 0) begin : g_bypass
    assign w_bypass = (r_count == '0) && w_in_ready && w_any_valid;

    // Select the lowest valid port's fields for the bypass output.
    always_comb begin
      w_byp_data = '0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (w_low_onehot[p]) w_byp_data = {in_output[p], in_row[p], in_col[p]};
      end
    end
  end else begin : g_no_bypass
    assign w_bypass   = 1'b0;
    assign w_byp_data = '0;
  end

  // A bypassed entry consumed this cycle never enters the buffer.
  assign w_byp_consumed = w_bypass && out_consume;
  assign w_store = w_in_ready ? (in_valid & ~(w_byp_consumed ? w_low_onehot : '0)) : '0;

  // Pack stored ports into consecutive slots starting at the write pointer.
  always_comb begin : c_slots
    logic [CNT_BITS-1:0] off;
    off    = '0;
    w_slot = '0;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      w_slot[p] = r_wr_ptr + off[PTR_BITS-1:0];
      off       = off + CNT_BITS'(w_store[p]);
    end
    w_nstore = off;
  end

  assign w_out_valid = reset && ((r_count != '0) || w_bypass);
  assign w_pop       = w_out_valid && out_consume && (r_count != '0) && !flush;
  assign w_overflow  = w_any_valid && !w_in_ready && !flush;

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign {out_output, out_row, out_col} = w_bypass ? w_byp_data : r_mem[r_rd_ptr];
  assign count        = r_count;
  assign almost_full  = (r_count >= C_AFULL);
  assign overflow_err = r_overflow;
  assign idle         = (r_count == '0) && !w_any_valid;

  // Entry storage: written only, never reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (w_store[p]) r_mem[w_slot[p]] <= {in_output[p], in_row[p], in_col[p]};
    end
  end

  // Occupancy, pointers and sticky overflow; flush overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count  <= r_count + w_nstore - CNT_BITS'(w_pop);
      r_wr_ptr <= r_wr_ptr + PTR_BITS'(w_nstore);
      r_rd_ptr <= r_rd_ptr + PTR_BITS'(w_pop);
      if (w_overflow) r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_collect_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_collect_fifo
// Description : Scoreboard bench for output_collect_fifo, with one bypass and
//               one non-bypass instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_collect_fifo;

  localparam int NWP = 4;
  localparam int NB  = 9;
  localparam int CB  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // Bypass-enabled instance signals
  logic [NWP-1:0]          in_valid = '0;
  logic [NWP-1:0][31:0]    in_output = '0;
  logic [NWP-1:0][NB-1:0]  in_row = '0, in_col = '0;
  logic                    in_ready, flush = 1'b0, out_valid, out_consume = 1'b0;
  logic [31:0]             out_output;
  logic [NB-1:0]           out_row, out_col;
  logic [CB-1:0]           count;
  logic                    almost_full, overflow_err, idle;

  // Bypass-disabled instance signals
  logic [NWP-1:0]          nb_valid = '0;
  logic [NWP-1:0][31:0]    nb_output = '0;
  logic [NWP-1:0][NB-1:0]  nb_row = '0, nb_col = '0;
  logic                    nb_in_ready, nb_out_valid, nb_consume = 1'b0;
  logic [31:0]             nb_out_output;
  logic [NB-1:0]           nb_out_row, nb_out_col;
  logic [CB-1:0]           nb_count;
  logic                    nb_afull, nb_overflow, nb_idle;

  int errors = 0;
  int checks = 0;
  logic [31+2*NB:0] exp_q[$];
  logic [31+2*NB:0] nb_q[$];

  output_collect_fifo #(.MAX_N(512), .NUM_WRITE_PORTS(NWP), .DEPTH(8), .BYPASS_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_output(in_output),
    .in_row(in_row), .in_col(in_col), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_output(out_output), .out_row(out_row),
    .out_col(out_col), .out_consume(out_consume), .count(count),
    .almost_full(almost_full), .overflow_err(overflow_err), .idle(idle));

  output_collect_fifo #(.MAX_N(512), .NUM_WRITE_PORTS(NWP), .DEPTH(8), .BYPASS_EN(0)) dut_nb (
    .clk(clk), .reset(reset), .in_valid(nb_valid), .in_output(nb_output),
    .in_row(nb_row), .in_col(nb_col), .in_ready(nb_in_ready), .flush(1'b0),
    .out_valid(nb_out_valid), .out_output(nb_out_output), .out_row(nb_out_row),
    .out_col(nb_out_col), .out_consume(nb_consume), .count(nb_count),
    .almost_full(nb_afull), .overflow_err(nb_overflow), .idle(nb_idle));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one write vector; row = port number, col = value[8:0].
  task automatic put(input bit sel, input logic [3:0] m, input logic [31:0] v0,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                     input bit push);
    logic [31:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int p = 0; p < NWP; p++) begin
      if (!sel) begin
        in_valid[p] = m[p]; in_output[p] = v[p];
        in_row[p] = NB'(p); in_col[p] = v[p][NB-1:0];
      end else begin
        nb_valid[p] = m[p]; nb_output[p] = v[p];
        nb_row[p] = NB'(p); nb_col[p] = v[p][NB-1:0];
      end
      if (push && m[p]) begin
        if (!sel) exp_q.push_back({v[p], NB'(p), v[p][NB-1:0]});
        else      nb_q.push_back({v[p], NB'(p), v[p][NB-1:0]});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: every consumed head is compared against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_consume) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: got %0h expected no output", out_output);
      end else if ({out_output, out_row, out_col} !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_data: got %0h expected %0h", {out_output, out_row, out_col}, exp_q[0]);
        void'(exp_q.pop_front());
      end else void'(exp_q.pop_front());
    end
    if (nb_out_valid && nb_consume) begin
      checks++;
      if (nb_q.size() == 0) begin
        errors++;
        $display("FAIL nb_pop_empty: got %0h expected no output", nb_out_output);
      end else if ({nb_out_output, nb_out_row, nb_out_col} !== nb_q[0]) begin
        errors++;
        $display("FAIL nb_pop_data: got %0h expected %0h", {nb_out_output, nb_out_row, nb_out_col}, nb_q[0]);
        void'(nb_q.pop_front());
      end else void'(nb_q.pop_front());
    end
  end

  initial begin
    // Reset asserted with a write pending: nothing may leak out.
    in_valid = 4'b0001; out_consume = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    cyc(); reset = 1'b1; in_valid = '0; out_consume = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", idle, 1);
    chk("in_ready_after_rst", in_ready, 1);

    // Bypass with ports 1 and 3, consumed immediately.
    cyc(); put(0, 4'b1010, 0, 'h11, 0, 'h33, 1); out_consume = 1'b1;
    @(negedge clk);
    chk("byp_valid", out_valid, 1);
    chk("byp_data", out_output, 'h11);
    cyc(); in_valid = '0; out_consume = 1'b0;
    @(negedge clk);
    chk("byp_count", count, 1);
    chk("byp_head", out_output, 'h33);
    cyc(); out_consume = 1'b1;
    cyc(); out_consume = 1'b0;
    @(negedge clk);
    chk("byp_drained", count, 0);
    chk("byp_out_valid", out_valid, 0);

    // Flush to return pointers to zero.
    cyc(); flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    cyc(); flush = 1'b0;

    // Wrap: 3 writes (bypass not consumed -> all stored), pop 3.
    put(0, 4'b0111, 'hA0, 'hA1, 'hA2, 0, 1);
    @(negedge clk);
    chk("wrap_byp_head", out_output, 'hA0);
    cyc(); in_valid = '0;
    @(negedge clk);
    chk("wrap_count3", count, 3);
    cyc(); out_consume = 1'b1;
    repeat (3) cyc();
    out_consume = 1'b0;
    // 4 writes land at slots 3..6.
    put(0, 4'b1111, 'hB0, 'hB1, 'hB2, 'hB3, 1);
    @(negedge clk);
    chk("wrap_count0", count, 0);
    // Simultaneous 4 writes and a pop at count 4.
    cyc(); put(0, 4'b1111, 'hC0, 'hC1, 'hC2, 'hC3, 1); out_consume = 1'b1;
    @(negedge clk);
    chk("sim_count4", count, 4);
    chk("sim_head_b0", out_output, 'hB0);
    chk("sim_in_ready", in_ready, 1);
    cyc(); in_valid = '0; out_consume = 1'b0;
    @(negedge clk);
    chk("sim_count7", count, 7);
    chk("sim_in_ready0", in_ready, 0);
    chk("sim_afull", almost_full, 1);
    chk("sim_head_b1", out_output, 'hB1);
    cyc(); out_consume = 1'b1;
    repeat (7) cyc();
    out_consume = 1'b0;
    @(negedge clk);
    chk("wrap_drained", count, 0);
    chk("wrap_idle", idle, 1);

    // Flush at count 5 with writes pending.
    cyc(); put(0, 4'b1111, 'hD0, 'hD1, 'hD2, 'hD3, 1);
    cyc(); put(0, 4'b0001, 'hE0, 0, 0, 0, 1);
    cyc(); put(0, 4'b1111, 'hF0, 'hF1, 'hF2, 'hF3, 0); flush = 1'b1;
    @(negedge clk);
    chk("flush_count5", count, 5);
    cyc(); in_valid = '0; flush = 1'b0; exp_q.delete();
    @(negedge clk);
    chk("flush_count0", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_no_ovf", overflow_err, 0);

    // Fill to 8, then an overflowing write.
    cyc(); put(0, 4'b1111, 'h10, 'h11, 'h12, 'h13, 1);
    cyc(); put(0, 4'b1111, 'h14, 'h15, 'h16, 'h17, 1);
    cyc(); put(0, 4'b1111, 'h18, 'h19, 'h1A, 'h1B, 0);
    @(negedge clk);
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    chk("full_ovf_before", overflow_err, 0);
    cyc(); in_valid = '0;
    @(negedge clk);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 8);
    cyc(); out_consume = 1'b1;
    repeat (8) cyc();
    out_consume = 1'b0;
    @(negedge clk);
    chk("ovf_drained", count, 0);
    chk("ovf_sticky", overflow_err, 1);
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow_err, 0);

    // Asynchronous reset mid-stream at count 6.
    cyc(); put(0, 4'b1111, 'h20, 'h21, 'h22, 'h23, 1);
    cyc(); put(0, 4'b0011, 'h24, 'h25, 0, 0, 1);
    cyc(); put(0, 4'b0001, 'h99, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_count6", count, 6);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    exp_q.delete();
    cyc(); reset = 1'b1; put(0, 4'b0001, 'h30, 0, 0, 0, 1);
    @(negedge clk);
    chk("post_rst_byp", out_output, 'h30);
    cyc(); in_valid = '0;
    @(negedge clk);
    chk("post_rst_count", count, 1);
    cyc(); out_consume = 1'b1;
    cyc(); out_consume = 1'b0;

    // Non-bypass instance: one-cycle latency, fill, overflow, drain order.
    put(1, 4'b1111, 'h40, 'h41, 'h42, 'h43, 1);
    @(negedge clk);
    chk("nb_latency", nb_out_valid, 0);
    cyc(); put(1, 4'b1111, 'h44, 'h45, 'h46, 'h47, 1);
    @(negedge clk);
    chk("nb_valid_next", nb_out_valid, 1);
    chk("nb_head", nb_out_output, 'h40);
    chk("nb_count4", nb_count, 4);
    cyc(); put(1, 4'b1111, 'h48, 'h49, 'h4A, 'h4B, 0);
    @(negedge clk);
    chk("nb_count8", nb_count, 8);
    chk("nb_in_ready0", nb_in_ready, 0);
    cyc(); nb_valid = '0;
    @(negedge clk);
    chk("nb_ovf", nb_overflow, 1);
    chk("nb_ovf_count", nb_count, 8);
    cyc(); nb_consume = 1'b1;
    repeat (8) cyc();
    nb_consume = 1'b0;
    @(negedge clk);
    chk("nb_drained", nb_count, 0);

    chk("sb_empty", exp_q.size(), 0);
    chk("nb_sb_empty", nb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
